// File: rtl/usb_tx_packer_pkg.sv
// Shared USB transmit-path types and constants: packer FSM states and CRC-16/USB parameters.
package usb_pkg;

  typedef enum logic [1:0] {
    TX_FILL,
    TX_CRC,
    TX_SHIFT,
    TX_WAIT_DONE
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY_REV      = 16'hA001;
  localparam logic [15:0] CRC16_INIT          = 16'hFFFF;
  localparam int unsigned MAX_PAYLOAD_DEFAULT = 64;

endpackage

// File: rtl/usb_tx_packer_crc16.sv
// Combinational CRC-16/USB next-state for one data byte (reflected, LSB first).
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data_in};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REV) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_packer.sv
// Transmit packet builder: collects payload bytes, appends CRC16, strobes shift_out
// and holds the packed vector until the ULPI transmitter reports completion.
module usb_tx_packer
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT,
  parameter int unsigned SHIFT_HOLD  = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  input  logic                           byte_last,
  input  logic                           flush,
  output logic                           byte_ready,
  input  logic                           tx_done,
  output logic [(MAX_PAYLOAD+2)*8-1:0]   packet_data,
  output logic [6:0]                     byte_count,
  output logic                           shift_out,
  output logic                           busy
);

  localparam int unsigned PD_W   = (MAX_PAYLOAD + 2) * 8;
  localparam int unsigned BASE_W = $clog2(PD_W);
  localparam int unsigned HOLD_W = $clog2(SHIFT_HOLD + 1);

  tx_state_t         state_q, state_d;
  logic [6:0]        wr_idx;
  logic [6:0]        wr_idx_p1;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       crc_q, crc_next;
  logic              accept, crc_wr, clear;
  logic [BASE_W-1:0] wr_base, hi_base;

  assign wr_idx_p1 = wr_idx + 7'd1;
  assign wr_base   = BASE_W'({wr_idx, 3'b000});
  assign hi_base   = BASE_W'({wr_idx_p1, 3'b000});

  usb_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data_in (byte_in),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= TX_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    busy       = 1'b1;
    shift_out  = 1'b0;
    accept     = 1'b0;
    crc_wr     = 1'b0;
    clear      = 1'b0;
    case (state_q)
      TX_FILL: begin
        byte_ready = 1'b1;
        busy       = 1'b0;
        accept     = byte_valid;
        // A byte arriving with flush is still taken; the packet then closes.
        if (flush || (byte_valid && (byte_last || wr_idx == 7'(MAX_PAYLOAD - 1))))
          state_d = TX_CRC;
      end
      TX_CRC: begin
        crc_wr  = 1'b1;
        state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        shift_out = 1'b1;
        if (hold_cnt == HOLD_W'(SHIFT_HOLD - 1)) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (tx_done) begin
          clear   = 1'b1;
          state_d = TX_FILL;
        end
      end
      default: state_d = TX_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_cnt <= '0;
    end else if (state_q == TX_SHIFT) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      packet_data <= '0;
      wr_idx      <= '0;
      byte_count  <= '0;
      crc_q       <= CRC16_INIT;
    end else if (clear) begin
      packet_data <= '0;
      wr_idx      <= '0;
      byte_count  <= '0;
      crc_q       <= CRC16_INIT;
    end else begin
      if (accept) begin
        packet_data[wr_base +: 8] <= byte_in;
        wr_idx                    <= wr_idx_p1;
        crc_q                     <= crc_next;
      end
      if (crc_wr) begin
        packet_data[wr_base +: 8] <= ~crc_q[7:0];
        packet_data[hi_base +: 8] <= ~crc_q[15:8];
        byte_count                <= wr_idx + 7'd2;
      end
    end
  end

endmodule

// File: doc/usb_tx_packer.md
# usb_tx_packer

Transmit-side packet builder feeding `usb_state_machine`. Accepts payload bytes one at a time from the endpoint logic, computes the USB CRC16 on the fly, and packs payload plus CRC into the 528-bit `internal_data_in` vector. It then pulses `shift_out` for the ULPI transmitter and holds the vector stable until the transfer completes. It lives entirely in the 180 MHz `clk` domain.

## Interface
- `MAX_PAYLOAD`, 64: maximum payload bytes per packet; the packed vector is (MAX_PAYLOAD+2)*8 bits.
- `SHIFT_HOLD`, 4: `clk` cycles `shift_out` stays high, so the 60 MHz `ulpi_clk` domain always samples it.
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `n_rst`  in  1  asynchronous active-low reset.
- `byte_in`  in  8  payload byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_last`  in  1  qualifies `byte_valid`; this is the final payload byte.
- `flush`  in  1  close the packet now; with zero bytes this produces a zero-length packet.
- `byte_ready`  out  1  packer accepts a byte this cycle.
- `tx_done`  in  1  one-cycle pulse: the transmitter finished shifting (synchronised `stp`).
- `packet_data`  out  528  byte k at bits [8k+7:8k]; drives `internal_data_in`.
- `byte_count`  out  7  total bytes to send, payload plus 2 CRC bytes (2..66).
- `shift_out`  out  1  start-transmit strobe.
- `busy`  out  1  high in any state other than FILL.

## Operation
- States: FILL, CRC, SHIFT, WAIT_DONE.
- **FILL**
  - `byte_ready`=1. A byte is accepted when `byte_valid`=1; it is written to slot `wr_idx`, `wr_idx` increments and the CRC updates.
  - Go to CRC when the accepted byte has `byte_last`=1, or when it is byte number MAX_PAYLOAD (auto-close even without `byte_last`), or when `flush`=1.
  - If `flush` and `byte_valid` are high together, the byte is accepted first, then the packet closes.
- **CRC** (1 cycle)
  - Write ~crc[7:0] to slot `wr_idx` and ~crc[15:8] to slot `wr_idx`+1.
  - `byte_count` = `wr_idx`+2. Go to SHIFT.
- **SHIFT**
  - `shift_out`=1 for exactly SHIFT_HOLD cycles, counted by `hold_cnt`, then go to WAIT_DONE.
- **WAIT_DONE**
  - On `tx_done`: clear `packet_data`, `wr_idx`, `byte_count`, and reset the CRC to 16'hFFFF. Return to FILL.
- `tx_done` outside WAIT_DONE is ignored. `byte_valid` outside FILL is ignored: nothing is written and nothing is lost, because `byte_ready`=0.
- CRC is CRC-16/USB: polynomial 0x8005, reflected (LSB-first, shift-right form uses 0xA001), init 0xFFFF, output complemented. The per-byte update is 8 unrolled bit steps in one cycle.
- Slots above `byte_count`-1 are always 8'h00.
- A reset at any point returns to FILL with all state cleared. A partially built packet is discarded.

## Timing
- Reset values: `byte_ready`=1, `shift_out`=0, `busy`=0, `packet_data`=0, `byte_count`=0, CRC=16'hFFFF, state FILL.
- Byte acceptance: a single-cycle handshake. Sustained 1 byte per cycle.
- Latency from the closing event (last byte or flush accepted at edge N):
  - CRC slots written at edge N+1.
  - `shift_out` high from after N+1 through N+1+SHIFT_HOLD.
- `packet_data` and `byte_count` are registered. They are stable from the first `shift_out` cycle until the `tx_done` edge.
- `byte_ready` returns high in the cycle after `tx_done` is sampled.

## Structure
- `usb_pkg`: the `tx_state_t` enum, the constants CRC16_POLY_REV = 16'hA001, CRC16_INIT = 16'hFFFF, and MAX_PAYLOAD_DEFAULT.
- Sub-module `usb_crc16`: combinational byte-wise next-CRC function, 16-bit CRC in, 8-bit data in, 16-bit CRC out. It is reused later by the receive-side checker.
- The top level holds the FSM, `wr_idx`, `hold_cnt`, and the packed register.

## Test plan
- Reset, then idle → `shift_out`=0, `byte_ready`=1, `packet_data`=0, `byte_count`=0.
- ASCII "123456789", 9 bytes, `byte_last` on '9' → bytes 0–8 = 31..39, byte 9 = 8'hC8, byte 10 = 8'hB4, `byte_count`=11; `shift_out` high for exactly 4 cycles starting 2 edges after the last byte.
- `flush` with no bytes → bytes 0,1 = 8'h00,8'h00; `byte_count`=2; `shift_out` asserted.
- 64 bytes alternating AA,BB with no `byte_last` → auto-close after byte 63, CRC in slots 64–65, `byte_count`=66; `byte_ready`=0 while byte 65 is presented and stays 0 until `tx_done`.
- `tx_done` pulsed during SHIFT → ignored; later `tx_done` in WAIT_DONE → vector cleared, FILL next cycle.
- `n_rst` asserted after 10 of 20 bytes → all outputs at reset values; the next packet "123456789" still yields CRC C8,B4.
